// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the core's
// combinational ALU: shift-add multiply, restoring divide (compare + subtract).
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [1:0]  md_op,
  input  logic [31:0] md_rs1,
  input  logic [31:0] md_rs2,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] md_result,
  output logic        alu_req,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_ADD = 3'd1,
    DIV_CMP = 3'd2,
    DIV_SUB = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state, state_d;
  logic [31:0] hi, hi_d, lo, lo_d, mcand, mcand_d, res_q, res_d;
  logic [4:0]  cnt, cnt_d;
  logic        lt, lt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] sum, rshift;
  logic        carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      cnt   <= '0;
      lt    <= 1'b0;
      op_q  <= '0;
      res_q <= '0;
    end else begin
      state <= state_d;
      hi    <= hi_d;
      lo    <= lo_d;
      mcand <= mcand_d;
      cnt   <= cnt_d;
      lt    <= lt_d;
      op_q  <= op_d;
      res_q <= res_d;
    end
  end

  always_comb begin
    state_d   = state;
    hi_d      = hi;
    lo_d      = lo;
    mcand_d   = mcand;
    cnt_d     = cnt;
    lt_d      = lt;
    op_d      = op_q;
    res_d     = res_q;
    sum       = hi;
    carry     = 1'b0;
    rshift    = {hi[30:0], lo[31]};
    alu_req   = 1'b0;
    alu_op    = ALU_ADD;
    alu_in1   = '0;
    alu_in2   = '0;
    md_busy   = (state != IDLE);
    md_done   = 1'b0;
    md_result = res_q;

    case (state)
      IDLE: begin
        if (md_start) begin
          op_d    = md_op;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = md_rs1;
          mcand_d = md_rs2;
          lt_d    = 1'b0;
          if (!md_op[1]) begin
            state_d = MUL_ADD;
          end else if (md_rs2 != '0) begin
            state_d = DIV_CMP;
          end else begin
            // Zero divisor: park the answer in hi/lo so DONE's selection still holds.
            state_d = DONE;
            if (md_op[0]) begin
              hi_d  = md_rs1;
              res_d = md_rs1;
            end else begin
              lo_d  = '1;
              res_d = '1;
            end
          end
        end
      end

      MUL_ADD: begin
        alu_req = 1'b1;
        alu_op  = ALU_ADD;
        alu_in1 = hi;
        alu_in2 = mcand;
        if (lo[0]) begin
          sum   = alu_out;
          carry = (alu_out < mcand);
        end
        {hi_d, lo_d} = {carry, sum, lo[31:1]};
        cnt_d = cnt + 5'd1;
        if (cnt == 5'd31) state_d = DONE;
      end

      DIV_CMP: begin
        alu_req = 1'b1;
        alu_op  = ALU_SLTU;
        alu_in1 = rshift;
        alu_in2 = mcand;
        // A bit shifted out of hi makes the partial remainder exceed any divisor.
        lt_d    = alu_out[0] & ~hi[31];
        hi_d    = rshift;
        lo_d    = {lo[30:0], 1'b0};
        state_d = DIV_SUB;
      end

      DIV_SUB: begin
        alu_req = 1'b1;
        alu_op  = ALU_SUB;
        alu_in1 = hi;
        alu_in2 = mcand;
        if (!lt) begin
          hi_d    = alu_out;
          lo_d[0] = 1'b1;
        end
        cnt_d   = cnt + 5'd1;
        state_d = (cnt == 5'd31) ? DONE : DIV_CMP;
      end

      DONE: begin
        md_done   = 1'b1;
        md_result = op_q[0] ? hi : lo;
        res_d     = md_result;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: behavioural ALU plus a plain-arithmetic
// reference for results and completion latency.
module tb_muldiv_seq;

  logic        clk, rst, md_start;
  logic [1:0]  md_op;
  logic [31:0] md_rs1, md_rs2;
  logic        md_busy, md_done, alu_req;
  logic [31:0] md_result, alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;

  int tests = 0;
  int fails = 0;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
    .md_rs1(md_rs1), .md_rs2(md_rs2), .md_busy(md_busy), .md_done(md_done),
    .md_result(md_result), .alu_req(alu_req), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out)
  );

  // Core ALU stand-in
  always_comb begin
    case (alu_op)
      4'b0000: alu_out = alu_in1 + alu_in2;
      4'b0001: alu_out = alu_in1 - alu_in2;
      4'b1001: alu_out = {31'd0, alu_in1 < alu_in2};
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0: ref_result = p[31:0];
      2'd1: ref_result = p[63:32];
      2'd2: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_cycle(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) ref_cycle = 33;
    else if (b == 0) ref_cycle = 1;
    else ref_cycle = 65;
  endfunction

  // Issue one operation and observe it to completion; optionally pokes md_start
  // with other operands at cycle `poke` while busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output logic [31:0] res, output int dcyc,
                        output int rfirst, output int rlast, output int rcount, output int busy_bad);
    dcyc = -1; rfirst = -1; rlast = -1; rcount = 0; busy_bad = 0; res = '0;
    @(negedge clk);
    md_start = 1'b1; md_op = op; md_rs1 = a; md_rs2 = b;
    @(posedge clk); #1;
    md_start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (!md_busy) busy_bad++;
      if (alu_req) begin
        rcount++;
        if (rfirst < 0) rfirst = c;
        rlast = c;
      end
      if (md_done) begin
        dcyc = c;
        res  = md_result;
        break;
      end
      if (c == poke) begin
        md_start = 1'b1; md_op = ~op; md_rs1 = $urandom; md_rs2 = $urandom;
      end else if (c == poke + 1) begin
        md_start = 1'b0;
      end
    end
    md_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; md_start = 1'b0; md_op = '0; md_rs1 = '0; md_rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({md_busy, md_done, alu_req} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got busy/done/req=%b want 000", {md_busy, md_done, alu_req});
    end
    tests++;
    if (md_result !== 32'd0) begin
      fails++; $display("FAIL reset_result got %h want 00000000", md_result);
    end
    tests++;
    if ({alu_op, alu_in1, alu_in2} !== 68'd0) begin
      fails++; $display("FAIL reset_alu got op=%h in1=%h in2=%h want 0/0/0", alu_op, alu_in1, alu_in2);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [9];
    logic [31:0] as  [9];
    logic [31:0] bs  [9];
    logic [31:0] res, exp;
    int dcyc, rf, rl, rc, bb, xreq;
    ops = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3};
    as  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h8000_0000, 32'h1234, 32'h1234, 32'hFFFF_FFFF};
    bs  = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd1, 32'd0, 32'd0, 32'h8000_0001};
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], 0, res, dcyc, rf, rl, rc, bb);
      exp = ref_result(ops[i], as[i], bs[i]);
      tests++;
      if (res !== exp) begin
        fails++; $display("FAIL dir%0d_result op=%0d a=%h b=%h got %h want %h", i, ops[i], as[i], bs[i], res, exp);
      end
      tests++;
      if (dcyc != ref_cycle(ops[i], bs[i])) begin
        fails++; $display("FAIL dir%0d_done_cycle got %0d want %0d", i, dcyc, ref_cycle(ops[i], bs[i]));
      end
      xreq = ref_cycle(ops[i], bs[i]) - 1;
      tests++;
      if (rc != xreq || (xreq > 0 && (rf != 1 || rl != xreq))) begin
        fails++; $display("FAIL dir%0d_alu_req got count=%0d first=%0d last=%0d want count=%0d cycles 1..%0d", i, rc, rf, rl, xreq, xreq);
      end
      tests++;
      if (bb != 0) begin
        fails++; $display("FAIL dir%0d_busy got %0d low cycles want 0", i, bb);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b, res, exp;
    int dcyc, rf, rl, rc, bb, bad_res, bad_cyc, bad_hold;
    bad_res = 0; bad_cyc = 0; bad_hold = 0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp = ref_result(op, a, b);
      run_op(op, a, b, 0, res, dcyc, rf, rl, rc, bb);
      if (res !== exp) begin
        bad_res++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, exp);
      end
      if (dcyc != ref_cycle(op, b)) begin
        bad_cyc++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", i, dcyc, ref_cycle(op, b));
      end
      @(negedge clk);
      if (md_result !== exp || md_done !== 1'b0) begin
        bad_hold++; $display("FAIL rnd%0d_hold got result=%h done=%b want %h/0", i, md_result, md_done, exp);
      end
    end
    tests++; if (bad_res != 0) fails++;
    tests++; if (bad_cyc != 0) fails++;
    tests++; if (bad_hold != 0) fails++;
  endtask

  task automatic test_start_while_busy;
    logic [31:0] res;
    int dcyc, rf, rl, rc, bb;
    run_op(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 10, res, dcyc, rf, rl, rc, bb);
    tests++;
    if (res !== ref_result(2'd1, 32'hDEAD_BEEF, 32'h1234_5678) || dcyc != 33) begin
      fails++; $display("FAIL busy_start_ignored got %h@%0d want %h@33", res, dcyc, ref_result(2'd1, 32'hDEAD_BEEF, 32'h1234_5678));
    end
  endtask

  task automatic test_abort;
    logic [31:0] res;
    int dcyc, rf, rl, rc, bb, bad;
    bad = 0;
    @(negedge clk);
    md_start = 1'b1; md_op = 2'd0; md_rs1 = 32'd7; md_rs2 = 32'd6;
    @(posedge clk); #1;
    md_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c > 10 && (alu_op !== 4'b0000 || md_done !== 1'b0 || md_busy !== 1'b1)) bad++;
      if (c == 10) begin md_start = 1'b1; md_op = 2'd2; md_rs1 = 32'd100; md_rs2 = 32'd7; end
      if (c == 11) md_start = 1'b0;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL abort_second_start got %0d disturbed cycles want 0", bad);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({md_busy, md_done, alu_req, alu_op} !== 7'd0 || md_result !== 32'd0 || alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin
      fails++; $display("FAIL abort_reset_outputs got busy=%b done=%b req=%b op=%h res=%h in1=%h in2=%h want all 0",
                        md_busy, md_done, alu_req, alu_op, md_result, alu_in1, alu_in2);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(2'd2, 32'd9, 32'd3, 0, res, dcyc, rf, rl, rc, bb);
    tests++;
    if (res !== 32'd3 || dcyc != 65) begin
      fails++; $display("FAIL abort_fresh_divu got %h@%0d want 00000003@65", res, dcyc);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int dcyc, rf, rl, rc, bb;
    run_op(2'd0, 32'd3, 32'd5, 0, res, dcyc, rf, rl, rc, bb);
    md_start = 1'b1; md_op = 2'd2; md_rs1 = 32'd50; md_rs2 = 32'd5;
    @(negedge clk);
    tests++;
    if (md_busy !== 1'b0 || md_done !== 1'b0 || md_result !== 32'd15) begin
      fails++; $display("FAIL b2b_done_start_ignored got busy=%b done=%b res=%h want 0/0/0000000f", md_busy, md_done, md_result);
    end
    @(posedge clk); #1;
    md_start = 1'b0;
    dcyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (md_done) begin dcyc = c; res = md_result; break; end
    end
    tests++;
    if (res !== 32'd10 || dcyc != 65) begin
      fails++; $display("FAIL b2b_next_accepted got %h@%0d want 0000000a@65", res, dcyc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
